// File: rtl/audio_mix_acc_if.sv
// Mono audio conditioning stage bus: slot stream, parallel sources, mute control and conditioned output.
// master drives the stimulus side, slave is the audio_mix_acc block.
interface audio_mix_acc_if #(
  parameter int NUM_SRC = 3,
  parameter int IN_W    = 9,
  parameter int OUT_W   = 16
);
  logic                       slot_clk;
  logic                       slot_last;
  logic signed [IN_W-1:0]     slot_data;
  logic [3:0]                 slot_gain;
  logic [NUM_SRC*OUT_W-1:0]   src_data;
  logic [NUM_SRC*4-1:0]       src_gain;
  logic                       mute;
  logic                       ramp_ce;
  logic signed [OUT_W-1:0]    audio_out;
  logic                       clip;
  logic                       slot_ovf;
  logic                       muted;

  modport master (
    output slot_clk, slot_last, slot_data, slot_gain, src_data, src_gain, mute, ramp_ce,
    input  audio_out, clip, slot_ovf, muted
  );

  modport slave (
    input  slot_clk, slot_last, slot_data, slot_gain, src_data, src_gain, mute, ramp_ce,
    output audio_out, clip, slot_ovf, muted
  );
endinterface

// File: rtl/audio_mix_acc.sv
// Slot accumulator + NUM_SRC gain mixer + saturation + soft mute ramp; 3-cycle mix latency, no backpressure.
// Define AUDIO_MIX_DC_BLOCK_EN to insert a DC-blocking high-pass before the mute multiply (4-cycle latency).
module audio_mix_acc #(
  parameter int NUM_SRC    = 3,
  parameter int IN_W       = 9,
  parameter int OUT_W      = 16,
  parameter int MAX_SLOTS  = 8,
  parameter int SLOT_SHIFT = 2,
  parameter int RAMP_W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  audio_mix_acc_if.slave bus
);

  localparam int CNT_W  = $clog2(MAX_SLOTS + 1);
  localparam int ACC_W  = IN_W + $clog2(MAX_SLOTS) + 1;
  localparam int SH_W   = ACC_W + SLOT_SHIFT;
  localparam int TERM_W = OUT_W + 3;
  localparam int PROD_W = OUT_W + 5;
  localparam int SUM_W  = TERM_W + $clog2(NUM_SRC + 1);
  localparam int LVL_W  = RAMP_W + 1;
  localparam int MUL_W  = OUT_W + LVL_W + 1;
  localparam int WIDE   = SUM_W + SH_W + 1;

  localparam logic [LVL_W-1:0]       LVL_MAX = {1'b1, {RAMP_W{1'b0}}};
  localparam logic [LVL_W-1:0]       LVL_ONE = {{RAMP_W{1'b0}}, 1'b1};
  localparam logic signed [WIDE-1:0] SAT_HI  = {{(WIDE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_LO  = {{(WIDE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat_val(input logic signed [WIDE-1:0] x);
    if (x > SAT_HI)      sat_val = SAT_HI[OUT_W-1:0];
    else if (x < SAT_LO) sat_val = SAT_LO[OUT_W-1:0];
    else                 sat_val = x[OUT_W-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [WIDE-1:0] x);
    sat_hit = (x > SAT_HI) || (x < SAT_LO);
  endfunction

  // ---------------- slot path ----------------
  logic                     r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                     r_slast_s1, r_slast_s2;
  logic signed [IN_W-1:0]   r_sdat_s1, r_sdat_s2;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [OUT_W-1:0]  r_slot_sum;
  logic                     r_slot_ovf;

  logic                     w_slot_fall;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [SH_W-1:0]   w_acc_shift;

  assign w_slot_fall = r_sclk_d & ~r_sclk_s2;
  assign w_acc_sum   = r_acc + ACC_W'(r_sdat_s2);
  assign w_acc_shift = SH_W'(w_acc_sum) <<< SLOT_SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_s1  <= 1'b0;
      r_sclk_s2  <= 1'b0;
      r_sclk_d   <= 1'b0;
      r_slast_s1 <= 1'b0;
      r_slast_s2 <= 1'b0;
      r_sdat_s1  <= '0;
      r_sdat_s2  <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_slot_sum <= '0;
      r_slot_ovf <= 1'b0;
    end else begin
      r_sclk_s1  <= bus.slot_clk;
      r_sclk_s2  <= r_sclk_s1;
      r_sclk_d   <= r_sclk_s2;
      r_slast_s1 <= bus.slot_last;
      r_slast_s2 <= r_slast_s1;
      r_sdat_s1  <= bus.slot_data;
      r_sdat_s2  <= r_sdat_s1;
      r_slot_ovf <= 1'b0;
      if (w_slot_fall) begin
        if (r_slast_s2) begin
          r_slot_sum <= sat_val(WIDE'(w_acc_shift));
          r_acc      <= '0;
          r_cnt      <= '0;
        end else if (r_cnt == CNT_W'(MAX_SLOTS)) begin
          // Runaway frame: drop this slot and restart, keep the last good sample.
          r_slot_ovf <= 1'b1;
          r_acc      <= '0;
          r_cnt      <= '0;
        end else begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- mix S1: per-term gain ----------------
  logic signed [TERM_W-1:0] w_term [NUM_SRC+1];
  logic signed [TERM_W-1:0] r_term [NUM_SRC+1];

  for (genvar g = 0; g <= NUM_SRC; g++) begin : g_term
    logic signed [OUT_W-1:0]  w_val;
    logic [3:0]               w_gain;
    logic signed [PROD_W-1:0] w_prod;
    if (g == 0) begin : g_slot
      assign w_val  = r_slot_sum;
      assign w_gain = bus.slot_gain;
    end else begin : g_src
      assign w_val  = bus.src_data[(g-1)*OUT_W +: OUT_W];
      assign w_gain = bus.src_gain[(g-1)*4 +: 4];
    end
    assign w_prod    = PROD_W'(w_val) * $signed({{(PROD_W-4){1'b0}}, w_gain});
    assign w_term[g] = TERM_W'(w_prod >>> 2);
  end

  // ---------------- mix S2: full-width sum ----------------
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] r_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i <= NUM_SRC; i++) begin
      w_sum = w_sum + SUM_W'(r_term[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NUM_SRC; i++) r_term[i] <= '0;
      r_sum <= '0;
    end else begin
      for (int i = 0; i <= NUM_SRC; i++) r_term[i] <= w_term[i];
      r_sum <= w_sum;
    end
  end

  // ---------------- mix S3: saturate, optional DC block ----------------
  logic signed [OUT_W-1:0] w_mix_in;
  logic                    w_mix_clip;

`ifdef AUDIO_MIX_DC_BLOCK_EN
  logic signed [OUT_W-1:0]  r_sat;
  logic                     r_sat_clip;
  logic signed [OUT_W-1:0]  r_dc_x;
  logic signed [OUT_W-1:0]  r_dc_y;
  logic signed [TERM_W-1:0] w_dc_sum;

  assign w_dc_sum   = TERM_W'(r_sat) - TERM_W'(r_dc_x) + TERM_W'(r_dc_y) - TERM_W'(r_dc_y >>> 10);
  assign w_mix_in   = sat_val(WIDE'(w_dc_sum));
  assign w_mix_clip = r_sat_clip | sat_hit(WIDE'(w_dc_sum));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat      <= '0;
      r_sat_clip <= 1'b0;
      r_dc_x     <= '0;
      r_dc_y     <= '0;
    end else begin
      r_sat      <= sat_val(WIDE'(r_sum));
      r_sat_clip <= sat_hit(WIDE'(r_sum));
      r_dc_x     <= r_sat;
      r_dc_y     <= w_mix_in;
    end
  end
`else
  assign w_mix_in   = sat_val(WIDE'(r_sum));
  assign w_mix_clip = sat_hit(WIDE'(r_sum));
`endif

  // ---------------- mute ramp FSM ----------------
  typedef enum logic [1:0] {
    ST_PLAY,
    ST_FADE_OUT,
    ST_SILENT,
    ST_FADE_IN
  } state_t;

  state_t           r_state;
  logic [LVL_W-1:0] r_level;
  logic             r_muted;
  logic [LVL_W-1:0] w_lvl_nxt;

  // Direction follows the current mute request, so a mute change and a strobe in the same cycle step the new way.
  always_comb begin
    w_lvl_nxt = r_level;
    if (bus.ramp_ce) begin
      if (bus.mute && (r_level != '0))        w_lvl_nxt = r_level - LVL_ONE;
      else if (!bus.mute && (r_level != LVL_MAX)) w_lvl_nxt = r_level + LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SILENT;
      r_level <= '0;
      r_muted <= 1'b1;
    end else begin
      r_level <= w_lvl_nxt;
      case (r_state)
        ST_PLAY: begin
          r_muted <= 1'b0;
          if (bus.mute) r_state <= ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          if (!bus.mute) begin
            r_state <= (w_lvl_nxt == LVL_MAX) ? ST_PLAY : ST_FADE_IN;
            r_muted <= 1'b0;
          end else if (w_lvl_nxt == '0) begin
            r_state <= ST_SILENT;
            r_muted <= 1'b1;
          end
        end
        ST_SILENT: begin
          if (!bus.mute) begin
            r_state <= ST_FADE_IN;
            r_muted <= 1'b0;
          end
        end
        ST_FADE_IN: begin
          if (bus.mute) begin
            r_state <= (w_lvl_nxt == '0) ? ST_SILENT : ST_FADE_OUT;
            r_muted <= (w_lvl_nxt == '0);
          end else if (w_lvl_nxt == LVL_MAX) begin
            r_state <= ST_PLAY;
          end
        end
        default: begin
          r_state <= ST_SILENT;
          r_muted <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- output: level multiply ----------------
  logic signed [MUL_W-1:0] w_mul;
  logic signed [OUT_W-1:0] w_ramped;
  logic signed [OUT_W-1:0] r_audio_out;
  logic                    r_clip;

  assign w_mul    = MUL_W'(w_mix_in) * $signed({{(MUL_W-LVL_W){1'b0}}, r_level});
  assign w_ramped = OUT_W'(w_mul >>> RAMP_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_audio_out <= '0;
      r_clip      <= 1'b0;
    end else begin
      r_audio_out <= w_ramped;
      r_clip      <= w_mix_clip;
    end
  end

  assign bus.audio_out = r_audio_out;
  assign bus.clip      = r_clip;
  assign bus.slot_ovf  = r_slot_ovf;
  assign bus.muted     = r_muted;

endmodule

// File: tb/tb_audio_mix_acc.sv
// Directed bench for audio_mix_acc at default parameters, default build (no DC block).
module tb_audio_mix_acc;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   ovf_cycles = 0;

  audio_mix_acc_if #(.NUM_SRC(3), .IN_W(9), .OUT_W(16)) bus ();

  audio_mix_acc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.slot_ovf === 1'b1) ovf_cycles <= ovf_cycles + 1;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic slot_edge(input logic signed [8:0] d, input logic last);
    @(negedge clk);
    bus.slot_data = d;
    bus.slot_last = last;
    bus.slot_clk  = 1'b1;
    repeat (3) @(negedge clk);
    bus.slot_clk  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ramp(input int n);
    @(negedge clk);
    bus.ramp_ce = 1'b1;
    repeat (n) @(negedge clk);
    bus.ramp_ce = 1'b0;
  endtask

  logic signed [15:0] s_val;

  initial begin
    reset         = 1'b1;
    bus.slot_clk  = 1'b0;
    bus.slot_last = 1'b0;
    bus.slot_data = '0;
    bus.slot_gain = 4'd4;
    bus.src_data  = '0;
    bus.src_gain  = '0;
    bus.mute      = 1'b0;
    bus.ramp_ce   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_audio", bus.audio_out, 0);
    chk("reset_clip", bus.clip, 0);
    chk("reset_ovf", bus.slot_ovf, 0);
    chk("reset_muted", bus.muted, 1);

    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("fadein_unmuted", bus.muted, 0);

    // 1: six slots of 100 -> 600 <<< 2 = 2400
    for (int i = 0; i < 6; i++) slot_edge(9'sd100, i == 5);
    settle();
    chk("t1_level0", bus.audio_out, 0);
    ramp(100);
    settle();
    chk("t1_level100", bus.audio_out, 937);
    ramp(157);
    settle();
    chk("t1_full", bus.audio_out, 2400);
    chk("t1_noclip", bus.clip, 0);

    // 2: saturation both ways
    bus.slot_gain = 4'd0;
    bus.src_gain  = {4'd4, 4'd4, 4'd4};
    s_val = 16'sd30000;
    bus.src_data = {16'h0000, s_val, s_val};
    settle();
    chk("t2_pos_sat", bus.audio_out, 32767);
    chk("t2_pos_clip", bus.clip, 1);
    s_val = -16'sd30000;
    bus.src_data = {16'h0000, s_val, s_val};
    settle();
    chk("t2_neg_sat", bus.audio_out, -32768);
    chk("t2_neg_clip", bus.clip, 1);
    bus.slot_gain = 4'd4;
    bus.src_gain  = '0;
    bus.src_data  = '0;
    settle();
    chk("t2_restore", bus.audio_out, 2400);
    chk("t2_clip_clear", bus.clip, 0);

    // 3: fade out
    bus.mute = 1'b1;
    ramp(128);
    settle();
    chk("t3_half", bus.audio_out, 1200);
    chk("t3_not_muted", bus.muted, 0);
    ramp(128);
    settle();
    chk("t3_silent", bus.audio_out, 0);
    chk("t3_muted", bus.muted, 1);

    // 4: reverse mid fade-out at level 100
    bus.mute = 1'b0;
    ramp(256);
    settle();
    chk("t4_full", bus.audio_out, 2400);
    bus.mute = 1'b1;
    ramp(156);
    settle();
    chk("t4_lvl100", bus.audio_out, 937);
    bus.mute = 1'b0;
    ramp(155);
    settle();
    chk("t4_lvl255", bus.audio_out, 2390);
    ramp(1);
    settle();
    chk("t4_play", bus.audio_out, 2400);
    chk("t4_unmuted", bus.muted, 0);
    ramp(5);
    settle();
    chk("t4_limit", bus.audio_out, 2400);

    // 5: overflow on the ninth slot without slot_last
    for (int i = 0; i < 8; i++) slot_edge(9'sd50, 1'b0);
    settle();
    chk("t5_no_ovf_8", ovf_cycles, 0);
    slot_edge(9'sd50, 1'b0);
    settle();
    chk("t5_ovf_once", ovf_cycles, 1);
    chk("t5_sum_held", bus.audio_out, 2400);
    slot_edge(9'sd100, 1'b0);
    slot_edge(9'sd100, 1'b1);
    settle();
    chk("t5_fresh_frame", bus.audio_out, 800);
    chk("t5_ovf_total", ovf_cycles, 1);

    // 6: asynchronous reset mid fade-in
    bus.mute = 1'b1;
    ramp(256);
    bus.mute = 1'b0;
    ramp(50);
    settle();
    chk("t6_lvl50", bus.audio_out, 156);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_audio", bus.audio_out, 0);
    chk("t6_async_muted", bus.muted, 1);
    @(negedge clk);
    reset = 1'b0;
    slot_edge(9'sd100, 1'b0);
    slot_edge(9'sd100, 1'b1);
    settle();
    chk("t6_restart_lvl0", bus.audio_out, 0);
    ramp(128);
    settle();
    chk("t6_restart_lvl128", bus.audio_out, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/audio_mix_acc.md
Name: audio_mix_acc

Overview:
- Parametrised mono audio conditioning stage; instantiate one per channel for stereo.
- Accumulates a time-multiplexed DAC slot stream, clocked by an external slot clock, into one frame sample.
- Mixes that sample with NUM_SRC parallel sources, each with its own gain, then saturates to OUT_W.
- Applies a click-free soft mute ramp; sits between the sound chips and the final LPF.

Parameters:
NUM_SRC, 3, number of parallel signed sources mixed with the slot sample
IN_W, 9, slot_data width (signed)
OUT_W, 16, source and output width (signed)
MAX_SLOTS, 8, slot edges allowed per frame before overflow
SLOT_SHIFT, 2, left shift applied to the accumulated frame sum
RAMP_W, 8, mute level resolution (unity = 2^RAMP_W)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
slot_clk  in  1  asynchronous slot clock; a slot is taken on its falling edge
slot_last  in  1  marks the final slot of a frame; sampled with slot_data
slot_data  in  IN_W  signed slot value
slot_gain  in  4  unsigned slot-sample gain, Q2.2 (4 = unity)
src_data  in  NUM_SRC*OUT_W  packed signed sources; source 0 in the LSBs
src_gain  in  NUM_SRC*4  packed Q2.2 gains, one per source
mute  in  1  requests fade to silence
ramp_ce  in  1  one-cycle strobe that advances the mute ramp by one step
audio_out  out  OUT_W  conditioned signed output
clip  out  1  high on any cycle where the output saturated
slot_ovf  out  1  one-cycle pulse on frame overflow
muted  out  1  high in SILENT state

Behaviour:
Reset (asynchronous, active-high):
- All registers clear; audio_out=0, clip=0, slot_ovf=0, muted=1.
- FSM enters SILENT with level=0, so the output fades in after reset and does not pop.

Slot path:
- slot_clk, slot_last and slot_data pass through a 2-FF synchroniser, followed by an edge register.
- A falling edge is detected on the 3rd clk after the edge at the pin.
- On a detected edge: acc <= acc + sign-extended slot_data; acc width is IN_W+clog2(MAX_SLOTS)+1.
- If slot_last is set on that edge:
  - slot_sum <= sat_OUT_W((acc + slot_data) <<< SLOT_SHIFT)
  - acc <= 0
  - slot count <= 0
- If the edge count reaches MAX_SLOTS+1 without slot_last:
  - slot_ovf pulses for one cycle
  - acc and count clear
  - the current slot is discarded
  - slot_sum is held unchanged

Mix pipeline (3 cycles from a slot_sum/src_data change to audio_out):
- S1: each term = (value * gain) >>> 2, computed signed at OUT_W+3 bits.
- S2: sum of all NUM_SRC+1 terms at full width (OUT_W+3+clog2(NUM_SRC+1) bits).
- S3: saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; clip is set for this cycle if saturation occurred. audio_out = (sat * level) >>> RAMP_W.
- When level = 2^RAMP_W the ramp multiply is exact, so audio_out equals the saturated sum.

Mute FSM (level ranges 0..2^RAMP_W):
- PLAY: level at maximum. mute=1 -> FADE_OUT.
- FADE_OUT: level decrements by 1 on each ramp_ce. Reaching 0 -> SILENT. mute=0 -> FADE_IN, continuing from the current level.
- SILENT: muted=1. mute=0 -> FADE_IN.
- FADE_IN: level increments by 1 on each ramp_ce. Reaching maximum -> PLAY. mute=1 -> FADE_OUT, continuing from the current level.
- A mute change and ramp_ce in the same cycle: the state changes first; the step applies in the new direction in that same cycle.
- ramp_ce while already at a limit has no effect.

Optional Feature:
AUDIO_MIX_DC_BLOCK_EN
- Defined: a first-order DC-blocking high-pass is inserted between S3 saturation and the mute multiply.
  - y = x - x_prev + y_prev - (y_prev >>> 10), updated every clk.
  - y is saturated to OUT_W.
  - Adds 1 cycle of latency (total 4).
  - Filter state resets to 0.
- Undefined: no filter, 3-cycle latency; a constant input passes through unchanged.

Test Plan:
1. Default parameters, all gains 4 except src_gain=0; six slot edges with slot_data=100, slot_last on the 6th -> slot_sum=2400. After 257 ramp_ce strobes, audio_out=2400.
2. src0=src1=30000 at gain 4, slot_gain=0, ramp complete -> audio_out=32767 and clip=1. With both sources at -30000 -> audio_out=-32768 and clip=1.
3. Ramp complete, output 2400. Assert mute and issue 128 ramp_ce -> level=128, audio_out=1200. After 128 more strobes -> audio_out=0 and muted=1.
4. Mid FADE_OUT at level 100, deassert mute -> FADE_IN from 100; 156 strobes later state is PLAY.
5. Nine slot edges with no slot_last -> slot_ovf pulses once on the 9th detected edge; slot_sum keeps its previous value; the next frame accumulates from 0.
6. Assert reset during FADE_IN at level 50 -> audio_out=0, muted=1, level=0 immediately (asynchronous). After release, fade-in restarts from 0.
